// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update datapath
// walks N_NEURONS virtual neurons per timestep, with refractory tracking.
module lif_scheduler #(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned REFRACT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   threshold,
  input  logic [7:0]                   current,
  output logic [$clog2(N_NEURONS)-1:0] cur_idx,
  output logic                         busy,
  output logic                         done,
  output logic [N_NEURONS-1:0]         spikes,
  input  logic [$clog2(N_NEURONS)-1:0] state_sel,
  output logic [7:0]                   state_out
);

  localparam int unsigned IDX_W  = $clog2(N_NEURONS);
  localparam int unsigned V_W    = 8;
  localparam int unsigned REFR_W = 3;

  typedef enum logic [1:0] {IDLE, UPDATE, FINISH} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [V_W-1:0]      thr_q;
  logic [V_W-1:0]      v    [N_NEURONS];
  logic [REFR_W-1:0]   refr [N_NEURONS];
  logic [N_NEURONS-1:0] shadow;

  logic [V_W-1:0]      v_cur;
  logic [REFR_W-1:0]   refr_cur;
  logic [V_W:0]        sum9;
  logic [V_W-1:0]      next_v;
  logic                fire;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = UPDATE;
      UPDATE:  if (idx == IDX_W'(N_NEURONS - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared leak/integrate/fire datapath for the neuron at idx
  always_comb begin
    v_cur    = v[idx];
    refr_cur = refr[idx];
    sum9     = (V_W+1)'(v_cur >> 1) + (V_W+1)'(current);
    next_v   = sum9[V_W] ? {V_W{1'b1}} : sum9[V_W-1:0];
    fire     = (refr_cur == '0) && (next_v >= thr_q);
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      thr_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      shadow <= '0;
      spikes <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == UPDATE);
      done  <= (state_nxt == FINISH);
      case (state)
        IDLE: if (start) begin
          thr_q <= threshold;
          idx   <= '0;
        end
        UPDATE: begin
          // idx wraps back to 0 after the last neuron, keeping cur_idx 0 outside UPDATE
          idx         <= idx + IDX_W'(1);
          shadow[idx] <= fire;
        end
        FINISH: spikes <= shadow;
        default: ;
      endcase
    end
  end

  // Per-neuron membrane and refractory state; only the neuron at idx moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        v[i]    <= '0;
        refr[i] <= '0;
      end
    end else if (state == UPDATE) begin
      if (refr_cur != '0) begin
        v[idx]    <= '0;
        refr[idx] <= refr_cur - REFR_W'(1);
      end else if (fire) begin
        v[idx]    <= '0;
        refr[idx] <= REFR_W'(REFRACT);
      end else begin
        v[idx]    <= next_v;
      end
    end
  end

  assign cur_idx   = idx;
  assign state_out = v[state_sel];

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: table of per-timestep vectors with a result
// scoreboard, plus hand sequences for start-during-update and reset-during-update.
module tb_lif_scheduler;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      threshold = '0;
  logic [7:0]      current;
  logic [2:0]      cur_idx;
  logic            busy, done;
  logic [N-1:0]    spikes;
  logic [2:0]      state_sel = '0;
  logic [7:0]      state_out;
  logic [N-1:0][7:0] cur_vec = '0;

  lif_scheduler #(.N_NEURONS(N), .REFRACT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold), .current(current),
    .cur_idx(cur_idx), .busy(busy), .done(done), .spikes(spikes),
    .state_sel(state_sel), .state_out(state_out)
  );

  always #5 clk = ~clk;
  assign current = cur_vec[cur_idx];

  typedef struct packed {
    logic              rst_first;
    logic [7:0]        thr;
    logic [N-1:0][7:0] cur;
    logic [7:0]        exp_spk;
    logic [N-1:0][7:0] exp_v;
  } vec_t;

  vec_t              tab [14];
  logic [7:0]        sb_spk [$];
  logic [N-1:0][7:0] sb_v   [$];
  int                n_checks = 0;
  int                n_fail   = 0;

  function automatic vec_t mk(logic r, logic [7:0] thr, logic [63:0] cur,
                              logic [7:0] spk, logic [63:0] v);
    vec_t t;
    t.rst_first = r;
    t.thr       = thr;
    t.cur       = cur;
    t.exp_spk   = spk;
    t.exp_v     = v;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check_v(input string tag, input logic [N-1:0][7:0] ev);
    for (int i = 0; i < N; i++) begin
      state_sel = 3'(i);
      #1;
      chk($sformatf("%s v[%0d]", tag, i), int'(state_out), int'(ev[i]));
    end
  endtask

  // One timestep: drive, push expectations, walk UPDATE, pop on done
  task automatic run_step(input int r, input bit mid_start);
    vec_t t;
    int   cnt;
    logic [7:0]        es;
    logic [N-1:0][7:0] ev;
    t = tab[r];
    if (t.rst_first) do_reset();
    cur_vec   = t.cur;
    threshold = t.thr;
    start     = 1'b1;
    sb_spk.push_back(t.exp_spk);
    sb_v.push_back(t.exp_v);
    @(posedge clk); #1;
    start     = 1'b0;
    threshold = 8'hAA;
    cnt = 0;
    while (!done && cnt < 4*N) begin
      chk($sformatf("rec%0d busy c%0d", r, cnt), int'(busy), 1);
      chk($sformatf("rec%0d cur_idx c%0d", r, cnt), int'(cur_idx), cnt);
      if (mid_start && cnt == 4) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt++;
    end
    // done rises N edges after the accepting edge
    chk($sformatf("rec%0d done latency", r), cnt, N);
    chk($sformatf("rec%0d busy in finish", r), int'(busy), 0);
    chk($sformatf("rec%0d cur_idx in finish", r), int'(cur_idx), 0);
    @(posedge clk); #1;
    chk($sformatf("rec%0d done one cycle", r), int'(done), 0);
    chk($sformatf("rec%0d scoreboard depth", r), sb_spk.size(), 1);
    if (sb_spk.size() > 0) begin
      es = sb_spk.pop_front();
      ev = sb_v.pop_front();
      chk($sformatf("rec%0d spikes", r), int'(spikes), int'(es));
      check_v($sformatf("rec%0d", r), ev);
    end
  endtask

  initial begin
    int extra;
    tab[0]  = mk(1'b1, 8'd200, 64'h0a0a0a0a_0a0a0a0a, 8'h00, 64'h0a0a0a0a_0a0a0a0a);
    tab[1]  = mk(1'b0, 8'd200, 64'h0a0a0a0a_0a0a0a0a, 8'h00, 64'h0f0f0f0f_0f0f0f0f);
    tab[2]  = mk(1'b0, 8'd20,  64'h00000000_1e000000, 8'h08, 64'h07070707_00070707);
    tab[3]  = mk(1'b0, 8'd20,  64'h00000000_1e000000, 8'h00, 64'h03030303_00030303);
    tab[4]  = mk(1'b0, 8'd20,  64'h00000000_1e000000, 8'h00, 64'h01010101_00010101);
    tab[5]  = mk(1'b0, 8'd20,  64'h00000000_1e000000, 8'h08, 64'h00000000_00000000);
    tab[6]  = mk(1'b1, 8'd255, 64'h00000000_00c8c8c8, 8'h00, 64'h00000000_00c8c8c8);
    tab[7]  = mk(1'b0, 8'd255, 64'h00000000_009b9aff, 8'h05, 64'h00000000_0000fe00);
    tab[8]  = mk(1'b1, 8'd0,   64'h0,                 8'hff, 64'h0);
    tab[9]  = mk(1'b0, 8'd0,   64'h0,                 8'h00, 64'h0);
    tab[10] = mk(1'b0, 8'd0,   64'h0,                 8'h00, 64'h0);
    tab[11] = mk(1'b0, 8'd0,   64'h0,                 8'hff, 64'h0);
    tab[12] = mk(1'b1, 8'd200, 64'h0a0a0a0a_0a0a0a0a, 8'h00, 64'h0a0a0a0a_0a0a0a0a);
    tab[13] = mk(1'b0, 8'd200, 64'h0a0a0a0a_0a0a0a0a, 8'h00, 64'h0a0a0a0a_0a0a0a0a);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset cur_idx", int'(cur_idx), 0);
    chk("reset spikes", int'(spikes), 0);
    check_v("reset", '0);
    rst = 1'b0;

    for (int r = 0; r < 12; r++) run_step(r, 1'b0);

    // Start pulsed mid-update must neither restart nor queue a second timestep
    run_step(12, 1'b1);
    extra = 0;
    for (int k = 0; k < 3*N; k++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("no queued timestep", extra, 0);

    // Reset during update aborts without a done pulse
    cur_vec   = 64'h0a0a0a0a_0a0a0a0a;
    threshold = 8'd200;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort mid index", int'(cur_idx), 5);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort cur_idx", int'(cur_idx), 0);
    check_v("abort", '0);
    @(posedge clk); #1 rst = 1'b0;
    extra = 0;
    for (int k = 0; k < 2*N; k++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("abort no done", extra, 0);
    run_step(13, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
